// File: rtl/cpu64_l3_obi_responder_if.sv
// cpu64_l3_obi_responder_if: L2<->L3 OBI port plus the L3->L2 back-invalidate handshake
interface cpu64_l3_obi_responder_if;
  logic        req_i;
  logic        we_i;
  logic [7:0]  be_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [63:0] rdata_o;
  logic        evict_valid_i;
  logic [63:0] evict_addr_i;
  logic        evict_ready_o;
  logic        binv_req_o;
  logic [63:0] binv_addr_o;
  logic        binv_ack_i;
  logic        binv_done_o;
  logic        oob_err_o;
  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, evict_valid_i, evict_addr_i, binv_ack_i,
    output gnt_o, rvalid_o, rdata_o, evict_ready_o, binv_req_o, binv_addr_o, binv_done_o, oob_err_o
  );
  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, evict_valid_i, evict_addr_i, binv_ack_i,
    input  gnt_o, rvalid_o, rdata_o, evict_ready_o, binv_req_o, binv_addr_o, binv_done_o, oob_err_o
  );
endinterface

// File: rtl/cpu64_l3_obi_responder.sv
// cpu64_l3_obi_responder: OBI responder with byte-enabled backing store and back-invalidate initiator
module cpu64_l3_obi_responder #(
  parameter int MEM_AW   = 12,
  parameter int READ_LAT = 2
) (
  input logic clk_i,
  input logic rst_i,
  cpu64_l3_obi_responder_if.slave bus
);
  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_DRAIN} bstate_e;
  logic [63:0] mem_q [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic in_range, gnt, rd, gap_q, oob_q;
  logic [63:0] rd_data;
  logic [READ_LAT-1:0] vld_q;
  logic [63:0] dat_q [READ_LAT];
  bstate_e state_q, state_d;
  logic binv_req_q, binv_req_d, done_q, done_d;
  logic [63:0] binv_addr_q, binv_addr_d;
  logic unused_bits;
  assign unused_bits = ^{bus.addr_i[2:0], bus.evict_addr_i[5:0]};
  assign idx      = bus.addr_i[MEM_AW+2:3];
  assign in_range = bus.addr_i[63:MEM_AW+3] == '0;
  // gap_q blocks the L2's lingering registered req from a second grant
  assign gnt      = bus.req_i && !gap_q && !rst_i;
  assign rd       = gnt && !bus.we_i;
  assign rd_data  = (rd && in_range) ? mem_q[idx] : '0;
  always_ff @(posedge clk_i)
    if (gnt && bus.we_i && in_range)
      for (int k = 0; k < 8; k++)
        if (bus.be_i[k]) mem_q[idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_q <= 1'b0;
      oob_q <= 1'b0;
      vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
    end else begin
      gap_q    <= gnt;
      oob_q    <= oob_q | (gnt && !in_range);
      vld_q[0] <= rd;
      dat_q[0] <= rd_data;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end
  always_comb begin
    state_d     = state_q;
    binv_req_d  = binv_req_q;
    binv_addr_d = binv_addr_q;
    done_d      = 1'b0;
    case (state_q)
      B_IDLE: if (bus.evict_valid_i) begin
        state_d     = B_WAIT;
        binv_req_d  = 1'b1;
        binv_addr_d = {bus.evict_addr_i[63:6], 6'b0};
      end
      B_WAIT: if (bus.binv_ack_i) begin
        state_d    = B_DRAIN;
        binv_req_d = 1'b0;
        done_d     = 1'b1;
      end
      default: state_d = B_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= B_IDLE;
      binv_req_q  <= 1'b0;
      binv_addr_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      binv_req_q  <= binv_req_d;
      binv_addr_q <= binv_addr_d;
      done_q      <= done_d;
    end
  end
  assign bus.gnt_o         = gnt;
  assign bus.rvalid_o      = vld_q[READ_LAT-1];
  assign bus.rdata_o       = dat_q[READ_LAT-1];
  assign bus.evict_ready_o = state_q == B_IDLE && !rst_i;
  assign bus.binv_req_o    = binv_req_q;
  assign bus.binv_addr_o   = binv_addr_q;
  assign bus.binv_done_o   = done_q;
  assign bus.oob_err_o     = oob_q;
endmodule

// File: tb/tb_cpu64_l3_obi_responder.sv
// tb_cpu64_l3_obi_responder: scoreboard bench, READ_LAT=2 instance plus a READ_LAT=4 instance for streaming
module tb_cpu64_l3_obi_responder;
  typedef struct {logic [63:0] d; int due;} exp_t;
  logic clk = 0, rst = 1, mirror = 0, req_b = 0;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t q_a[$], q_b[$];
  exp_t ea, eb;
  logic [63:0] stream_exp [3] = '{64'h0303030303030303, 64'h0808080808080808, 64'h1010101010101010};
  cpu64_l3_obi_responder_if bus_a();
  cpu64_l3_obi_responder_if bus_b();
  cpu64_l3_obi_responder #(.MEM_AW(12), .READ_LAT(2)) u_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  cpu64_l3_obi_responder #(.MEM_AW(12), .READ_LAT(4)) u_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));
  assign bus_b.req_i         = mirror ? bus_a.req_i : req_b;
  assign bus_b.we_i          = bus_a.we_i;
  assign bus_b.be_i          = bus_a.be_i;
  assign bus_b.addr_i        = bus_a.addr_i;
  assign bus_b.wdata_i       = bus_a.wdata_i;
  assign bus_b.evict_valid_i = 1'b0;
  assign bus_b.evict_addr_i  = '0;
  assign bus_b.binv_ack_i    = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (bus_a.rvalid_o) begin
    if (q_a.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rvalid_a: got unexpected response %h, required none", bus_a.rdata_o);
    end else begin
      ea = q_a.pop_front();
      chk("rdata_a", bus_a.rdata_o, ea.d);
      chk("rlat_a", 64'(cyc), 64'(ea.due));
    end
  end
  always @(negedge clk) if (bus_b.rvalid_o) begin
    if (q_b.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rvalid_b: got unexpected response %h, required none", bus_b.rdata_o);
    end else begin
      eb = q_b.pop_front();
      chk("rdata_b", bus_b.rdata_o, eb.d);
      chk("rlat_b", 64'(cyc), 64'(eb.due));
    end
  end
  task automatic op(input logic we, input logic [7:0] be, input logic [63:0] addr,
                    input logic [63:0] wd, input logic [63:0] rd_exp);
    int n = 0;
    bus_a.req_i = 1; bus_a.we_i = we; bus_a.be_i = be; bus_a.addr_i = addr; bus_a.wdata_i = wd;
    @(negedge clk);
    while (!bus_a.gnt_o && n < 20) begin @(negedge clk); n++; end
    chk("gnt", bus_a.gnt_o, 1);
    if (bus_a.gnt_o && !we) q_a.push_back('{rd_exp, cyc + 2});
    @(posedge clk); #1;
    @(negedge clk); chk("gap", bus_a.gnt_o, 0);
    @(posedge clk); #1 bus_a.req_i = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end
  initial begin
    bus_a.req_i = 1; bus_a.we_i = 0; bus_a.be_i = 0; bus_a.addr_i = 0; bus_a.wdata_i = 0;
    bus_a.evict_valid_i = 0; bus_a.evict_addr_i = 0; bus_a.binv_ack_i = 0;
    @(negedge clk);
    chk("gnt_in_rst", bus_a.gnt_o, 0);
    chk("ready_in_rst", bus_a.evict_ready_o, 0);
    idle(3);
    rst = 0; bus_a.req_i = 0;
    @(negedge clk);
    chk("rst_rvalid", bus_a.rvalid_o, 0);
    chk("rst_rdata", bus_a.rdata_o, 0);
    chk("rst_binv_req", bus_a.binv_req_o, 0);
    chk("rst_binv_addr", bus_a.binv_addr_o, 0);
    chk("rst_done", bus_a.binv_done_o, 0);
    chk("rst_oob", bus_a.oob_err_o, 0);
    chk("rst_ready", bus_a.evict_ready_o, 1);
    @(posedge clk); #1;
    mirror = 1;
    op(1, 8'hFF, 64'h300, stream_exp[0], 0);
    op(1, 8'hFF, 64'h308, stream_exp[1], 0);
    op(1, 8'hFF, 64'h310, stream_exp[2], 0);
    mirror = 0;
    op(1, 8'hFF, 64'h100, 64'h1122334455667788, 0);
    op(0, 8'h00, 64'h100, 0, 64'h1122334455667788);
    op(1, 8'h0F, 64'h100, 64'hAAAAAAAABBBBBBBB, 0);
    op(0, 8'h00, 64'h100, 0, 64'h11223344BBBBBBBB);
    op(1, 8'h00, 64'h100, 64'hFFFFFFFFFFFFFFFF, 0);
    op(0, 8'h00, 64'h100, 0, 64'h11223344BBBBBBBB);
    bus_a.evict_valid_i = 1; bus_a.evict_addr_i = 64'h12345;
    @(negedge clk); chk("ready_idle", bus_a.evict_ready_o, 1);
    @(posedge clk); #1 bus_a.evict_valid_i = 0;
    @(negedge clk);
    chk("binv_req", bus_a.binv_req_o, 1);
    chk("binv_addr", bus_a.binv_addr_o, 64'h12340);
    chk("ready_wait", bus_a.evict_ready_o, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) op(1, 8'hFF, 64'h200 + 64'(8 * i), 64'h0101010101010101 * 64'(i + 1), 0);
    chk("binv_req_held", bus_a.binv_req_o, 1);
    chk("binv_addr_held", bus_a.binv_addr_o, 64'h12340);
    bus_a.binv_ack_i = 1;
    @(negedge clk); chk("done_before", bus_a.binv_done_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("binv_req_clr", bus_a.binv_req_o, 0);
    chk("done_pulse", bus_a.binv_done_o, 1);
    chk("ready_drain", bus_a.evict_ready_o, 0);
    @(posedge clk); #1 bus_a.binv_ack_i = 0;
    @(negedge clk);
    chk("done_once", bus_a.binv_done_o, 0);
    chk("binv_req_idle", bus_a.binv_req_o, 0);
    chk("ready_back", bus_a.evict_ready_o, 1);
    @(posedge clk); #1;
    op(0, 8'h00, 64'h238, 0, 64'h0808080808080808);
    op(1, 8'hFF, 64'h0, 64'hCAFEF00DDEADBEEF, 0);
    chk("oob_clear", bus_a.oob_err_o, 0);
    op(0, 8'h00, 64'h1_0000_0000, 0, 64'h0);
    chk("oob_set", bus_a.oob_err_o, 1);
    op(1, 8'hFF, 64'h1_0000_0000, 64'h5555555555555555, 0);
    op(0, 8'h00, 64'h0, 0, 64'hCAFEF00DDEADBEEF);
    idle(4);
    chk("oob_sticky", bus_a.oob_err_o, 1);
    bus_a.evict_valid_i = 1; bus_a.evict_addr_i = 64'h40;
    @(posedge clk); #1 bus_a.evict_valid_i = 0;
    bus_a.req_i = 1; bus_a.we_i = 0; bus_a.addr_i = 64'h100;
    @(negedge clk);
    chk("binv_req_pre_rst", bus_a.binv_req_o, 1);
    chk("gnt_pre_rst", bus_a.gnt_o, 1);
    @(posedge clk); #1 bus_a.req_i = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("binv_req_post_rst", bus_a.binv_req_o, 0);
      chk("done_post_rst", bus_a.binv_done_o, 0);
    end
    chk("oob_post_rst", bus_a.oob_err_o, 0);
    @(posedge clk); #1;
    op(0, 8'h00, 64'h100, 0, 64'h11223344BBBBBBBB);
    req_b = 1; bus_a.we_i = 0; bus_a.addr_i = 64'h300;
    for (int i = 0, g = 0; i < 6; i++) begin
      @(negedge clk);
      chk("gnt_b_alt", bus_b.gnt_o, (i % 2 == 0) ? 1 : 0);
      if (bus_b.gnt_o && g < 3) begin
        q_b.push_back('{stream_exp[g], cyc + 4});
        g++;
      end
      @(posedge clk); #1;
      if (i % 2 == 1) bus_a.addr_i = bus_a.addr_i + 8;
    end
    req_b = 0;
    idle(10);
    chk("drain_a", 64'(q_a.size()), 0);
    chk("drain_b", 64'(q_b.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
